popcount_serial: RTL and testbench
==================================

// Module: popcount_serial
// PURPOSE
//   Multi-cycle population counter. On a start handshake, captures a DATA_W-bit operand
//   and counts its set bits (or its clear bits, per mode), consuming BITS_PER_CYC bits per clock.
//   Delivers the count with a one-cycle done pulse and holds it until the next result.
//   Sits beside datapath blocks that need bit counts and can tolerate multi-cycle latency
//   in exchange for small area.
// PARAMETERS
//   DATA_W        16                     operand width; >= 2
//   BITS_PER_CYC  1                      bits consumed per COUNT cycle; must divide DATA_W
//   CNT_W         $clog2(DATA_W+1)       result width; holds 0..DATA_W with no overflow
// PORTS
//   clk       in   1            clock; all state updates on rising edge
//   reset     in   1            synchronous, active-high reset
//   start     in   1            request; accepted only when busy==0 and reset==0
//   mode      in   1            sampled with start: 0 = count ones, 1 = count zeros
//   i_a       in   DATA_W       operand; sampled with start
//   busy      out  1            high while in COUNT
//   done      out  1            one-cycle pulse when no_ones is updated
//   no_ones   out  CNT_W        result of last completed operation; held
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, no_ones=0; shift register and accumulator cleared.
//   Reset wins over start in the same cycle.
// - FSM has two states:
//   - IDLE: on start, latch opnd = mode ? ~i_a : i_a; acc=0; cnt=N-1,
//     where N = DATA_W/BITS_PER_CYC; go to COUNT.
//   - COUNT: acc += popcount(opnd[BITS_PER_CYC-1:0]); opnd >>= BITS_PER_CYC.
//     At cnt==0: no_ones <= final sum; done <= 1; go to IDLE. Otherwise cnt--.
// - Timing, with start accepted in cycle T:
//   - busy=1 in cycles T+1..T+N.
//   - done=1 and the new no_ones appear in cycle T+N+1, where busy=0.
// - Back-to-back: start is accepted in the done cycle, so throughput is one result per N+1 cycles.
// - start while busy: ignored; no queuing; the in-flight result is unaffected.
// - mode and i_a are don't-care except in the accepting cycle.
// - done is never asserted for two consecutive cycles. no_ones changes only together with done.
// - Adder width: acc is CNT_W bits. Per-cycle increment is 0..BITS_PER_CYC. The all-ones
//   operand yields exactly DATA_W with no wrap.
// - Reset mid-COUNT: operation aborted; no done pulse; no_ones=0.
// CONFIGURATION
//   POPCNT_EARLY_EXIT_EN
//   - Defined:
//     - COUNT also ends on the edge where the remaining unshifted opnd is zero.
//       done follows in the next cycle with the exact count.
//     - If opnd (after mode inversion) is zero at accept: busy stays 0; done=1 at T+1; no_ones=0.
//     - Latency is variable, 1..N+1 cycles.
//   - Undefined: latency is always exactly N+1 cycles.
// TESTING
// 1. Reset, then start with i_a=16'hFFFF, mode=0 -> busy T+1..T+16; done at T+17;
//    no_ones=5'd16.
// 2. i_a=16'hA5A5, mode=1 -> no_ones=8.
//    Then i_a=16'h0001, mode=1, started in the done cycle -> no_ones=15,
//    with done 17 cycles after the previous done.
// 3. start i_a=16'h000F; pulse start again with i_a=16'hFFFF at T+3 -> single done at T+17;
//    no_ones=4.
// 4. start i_a=16'hFFFF; reset at T+5 -> no done pulse; no_ones=0; busy=0 from T+6.
//    A fresh start then behaves as in test 1.
// 5. BITS_PER_CYC=4, i_a=16'hF0F0, mode=0 -> done at T+5; no_ones=8.
// 6. POPCNT_EARLY_EXIT_EN, i_a=16'h0003 -> done at T+3; no_ones=2.
//    i_a=16'h0000 -> done at T+1; no_ones=0.
//    Without the macro, both cases complete at T+17.

Source files
------------

// File: rtl/popcount_serial.sv
// Serial population counter: counts ones (or zeros) of an operand, BITS_PER_CYC bits per clock.
// Optional feature macro POPCNT_EARLY_EXIT_EN ends the count once the unshifted remainder is zero.
module popcount_serial #(
   parameter int DATA_W       = 16,
   parameter int BITS_PER_CYC = 1,
   parameter int CNT_W        = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] i_a,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  no_ones
);

   localparam int N = DATA_W / BITS_PER_CYC;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] opnd, opnd_next, opnd_shift, operand;
   logic [CNT_W-1:0]  acc, acc_next, cnt, cnt_next;
   logic [CNT_W-1:0]  chunk_sum, sum, no_ones_next;
   logic              done_next, last_chunk, fast_zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         opnd    <= '0;
         acc     <= '0;
         cnt     <= '0;
         no_ones <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         opnd    <= opnd_next;
         acc     <= acc_next;
         cnt     <= cnt_next;
         no_ones <= no_ones_next;
         done    <= done_next;
      end
   end

   always_comb begin
      chunk_sum = '0;
      for (int i = 0; i < BITS_PER_CYC; i++) begin
         chunk_sum = chunk_sum + CNT_W'(opnd[i]);
      end
      sum        = acc + chunk_sum;
      opnd_shift = opnd >> BITS_PER_CYC;
      operand    = mode ? ~i_a : i_a;

      last_chunk = (cnt == '0);
      fast_zero  = 1'b0;
`ifdef POPCNT_EARLY_EXIT_EN
      last_chunk = last_chunk || (opnd_shift == '0);
      // Skipping COUNT entirely is only allowed outside a done cycle so done never pulses twice in a row.
      fast_zero  = (operand == '0) && !done;
`endif

      state_next   = state;
      opnd_next    = opnd;
      acc_next     = acc;
      cnt_next     = cnt;
      no_ones_next = no_ones;
      done_next    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (fast_zero) begin
                  no_ones_next = '0;
                  done_next    = 1'b1;
               end else begin
                  opnd_next  = operand;
                  acc_next   = '0;
                  cnt_next   = LAST_IDX;
                  state_next = COUNT;
               end
            end
         end
         COUNT: begin
            acc_next  = sum;
            opnd_next = opnd_shift;
            if (last_chunk) begin
               no_ones_next = sum;
               done_next    = 1'b1;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == COUNT);

endmodule

// File: tb/tb_popcount_serial.sv
// Self-checking bench for popcount_serial: directed scenarios plus randomized operands
// checked against an arithmetic model of count and latency, for 1 and 4 bits per cycle.
module tb_popcount_serial;

   logic        clk;
   logic        reset;
   logic        start, start4;
   logic        mode;
   logic [15:0] i_a;
   logic        busy, done, busy4, done4;
   logic [4:0]  no_ones, no_ones4;

   int checks   = 0;
   int failures = 0;

   popcount_serial #(.DATA_W(16), .BITS_PER_CYC(1)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .i_a(i_a),
      .busy(busy), .done(done), .no_ones(no_ones)
   );

   popcount_serial #(.DATA_W(16), .BITS_PER_CYC(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .mode(mode), .i_a(i_a),
      .busy(busy4), .done(done4), .no_ones(no_ones4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_count(input logic [15:0] a, input logic m);
      logic [15:0] op;
      op = m ? ~a : a;
      return $countones(op);
   endfunction

   // Cycles from the accepting cycle to the done cycle, assuming done was low when accepted.
   function automatic int model_latency(input logic [15:0] a, input logic m, input int b);
      logic [15:0] op;
      int          h;
      op = m ? ~a : a;
      h  = -1;
      for (int i = 15; i >= 0; i--) begin
         if (op[i] && h < 0) h = i;
      end
`ifdef POPCNT_EARLY_EXIT_EN
      if (h < 0) return 1;
      return h / b + 2;
`else
      return 16 / b + 1;
`endif
   endfunction

   // Starts an operation in the current cycle and follows it to its done cycle (or a timeout).
   task automatic applyStimulus(input logic [15:0] a, input logic m, input bit wide,
                                output int latency, output int busy_cycles,
                                output logic [4:0] result, output logic busy_at_done);
      i_a = a;
      mode = m;
      if (wide) start4 = 1'b1; else start = 1'b1;
      step();
      start  = 1'b0;
      start4 = 1'b0;
      i_a    = 16'($urandom);
      mode   = 1'($urandom);
      latency      = -1;
      busy_cycles  = 0;
      result       = 'x;
      busy_at_done = 1'bx;
      for (int k = 1; k <= 40; k++) begin
         if (wide ? done4 : done) begin
            latency      = k;
            result       = wide ? no_ones4 : no_ones;
            busy_at_done = wide ? busy4 : busy;
            break;
         end
         if (wide ? busy4 : busy) busy_cycles++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || no_ones !== 5'd0) begin
         failures++;
         $display("[TB] FAIL reset_state: busy=%b done=%b no_ones=%0d, want 0 0 0", busy, done, no_ones);
      end
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || no_ones4 !== 5'd0) begin
         failures++;
         $display("[TB] FAIL reset_state4: busy=%b done=%b no_ones=%0d, want 0 0 0", busy4, done4, no_ones4);
      end
      reset = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || no_ones !== 5'd0) begin
         failures++;
         $display("[TB] FAIL post_reset_idle: busy=%b done=%b no_ones=%0d, want 0 0 0", busy, done, no_ones);
      end
   endtask

   task automatic test_all_ones();
      int lat, bc;
      logic [4:0] res;
      logic bad;
      applyStimulus(16'hFFFF, 1'b0, 1'b0, lat, bc, res, bad);
      checks++;
      if (lat !== model_latency(16'hFFFF, 1'b0, 1)) begin
         failures++;
         $display("[TB] FAIL all_ones_latency: got %0d want %0d", lat, model_latency(16'hFFFF, 1'b0, 1));
      end
      checks++;
      if (bc !== 16) begin
         failures++;
         $display("[TB] FAIL all_ones_busy_cycles: got %0d want 16", bc);
      end
      checks++;
      if (res !== 5'd16 || bad !== 1'b0) begin
         failures++;
         $display("[TB] FAIL all_ones_result: no_ones=%0d busy=%b want 16 0", res, bad);
      end
      step();
      checks++;
      if (done !== 1'b0 || no_ones !== 5'd16) begin
         failures++;
         $display("[TB] FAIL all_ones_hold: done=%b no_ones=%0d want 0 16", done, no_ones);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      logic [4:0] res;
      logic bad;
      applyStimulus(16'hA5A5, 1'b1, 1'b0, lat, bc, res, bad);
      checks++;
      if (res !== 5'(model_count(16'hA5A5, 1'b1)) || lat !== model_latency(16'hA5A5, 1'b1, 1)) begin
         failures++;
         $display("[TB] FAIL b2b_first: no_ones=%0d lat=%0d want %0d %0d", res, lat,
                  model_count(16'hA5A5, 1'b1), model_latency(16'hA5A5, 1'b1, 1));
      end
      applyStimulus(16'h0001, 1'b1, 1'b0, lat, bc, res, bad);
      checks++;
      if (res !== 5'd15) begin
         failures++;
         $display("[TB] FAIL b2b_second_result: got %0d want 15", res);
      end
      checks++;
      if (lat !== 17) begin
         failures++;
         $display("[TB] FAIL b2b_done_spacing: got %0d want 17", lat);
      end
   endtask

   task automatic test_start_while_busy();
      int first_done, n_done;
      first_done = -1;
      n_done     = 0;
      step();
      i_a   = 16'h000F;
      mode  = 1'b0;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         start = (k == 3);
         if (k == 3) i_a = 16'hFFFF;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
      end
      start = 1'b0;
      checks++;
      if (n_done !== 1 || first_done !== model_latency(16'h000F, 1'b0, 1)) begin
         failures++;
         $display("[TB] FAIL busy_start_ignored: dones=%0d at=%0d want 1 at %0d", n_done, first_done,
                  model_latency(16'h000F, 1'b0, 1));
      end
      checks++;
      if (no_ones !== 5'd4) begin
         failures++;
         $display("[TB] FAIL busy_start_result: got %0d want 4", no_ones);
      end
   endtask

   task automatic test_reset_abort();
      int n_done, lat, bc;
      logic [4:0] res;
      logic bad;
      n_done = 0;
      i_a   = 16'hFFFF;
      mode  = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= 5; k++) step();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_busy_before: got %b want 1", busy);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || no_ones !== 5'd0) begin
         failures++;
         $display("[TB] FAIL abort_state: busy=%b no_ones=%0d want 0 0", busy, no_ones);
      end
      for (int k = 0; k < 25; k++) begin
         if (done) n_done++;
         step();
      end
      checks++;
      if (n_done !== 0) begin
         failures++;
         $display("[TB] FAIL abort_no_done: got %0d pulses want 0", n_done);
      end
      applyStimulus(16'hFFFF, 1'b0, 1'b0, lat, bc, res, bad);
      checks++;
      if (res !== 5'd16 || lat !== model_latency(16'hFFFF, 1'b0, 1) || bc !== 16) begin
         failures++;
         $display("[TB] FAIL abort_restart: no_ones=%0d lat=%0d busy=%0d want 16 %0d 16", res, lat, bc,
                  model_latency(16'hFFFF, 1'b0, 1));
      end
   endtask

   task automatic test_wide_step();
      int lat, bc;
      logic [4:0] res;
      logic bad;
      step();
      applyStimulus(16'hF0F0, 1'b0, 1'b1, lat, bc, res, bad);
      checks++;
      if (res !== 5'd8 || lat !== model_latency(16'hF0F0, 1'b0, 4)) begin
         failures++;
         $display("[TB] FAIL wide_step: no_ones=%0d lat=%0d want 8 %0d", res, lat,
                  model_latency(16'hF0F0, 1'b0, 4));
      end
   endtask

   task automatic test_early_exit();
      int lat, bc;
      logic [4:0] res;
      logic bad;
      step();
      applyStimulus(16'h0003, 1'b0, 1'b0, lat, bc, res, bad);
      checks++;
      if (res !== 5'd2 || lat !== model_latency(16'h0003, 1'b0, 1)) begin
         failures++;
         $display("[TB] FAIL early_small: no_ones=%0d lat=%0d want 2 %0d", res, lat,
                  model_latency(16'h0003, 1'b0, 1));
      end
      step();
      applyStimulus(16'h0000, 1'b0, 1'b0, lat, bc, res, bad);
      checks++;
      if (res !== 5'd0 || lat !== model_latency(16'h0000, 1'b0, 1) || bc !== lat - 1) begin
         failures++;
         $display("[TB] FAIL early_zero: no_ones=%0d lat=%0d busy=%0d want 0 %0d %0d", res, lat, bc,
                  model_latency(16'h0000, 1'b0, 1), model_latency(16'h0000, 1'b0, 1) - 1);
      end
   endtask

   task automatic test_random();
      int lat, bc, b;
      logic [4:0] res;
      logic bad;
      logic [15:0] a;
      logic m;
      bit wide;
      for (int n = 0; n < 24; n++) begin
         a    = 16'($urandom);
         m    = 1'($urandom);
         wide = 1'($urandom_range(0, 1));
         b    = wide ? 4 : 1;
         step();
         applyStimulus(a, m, wide, lat, bc, res, bad);
         checks++;
         if (res !== 5'(model_count(a, m)) || lat !== model_latency(a, m, b) || bc !== lat - 1 || bad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL random a=%h mode=%b b=%0d: no_ones=%0d lat=%0d busy=%0d want %0d %0d %0d",
                     a, m, b, res, lat, bc, model_count(a, m), model_latency(a, m, b),
                     model_latency(a, m, b) - 1);
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      start4 = 1'b0;
      mode   = 1'b0;
      i_a    = '0;
      test_reset();
      test_all_ones();
      test_back_to_back();
      test_start_while_busy();
      test_reset_abort();
      test_wide_step();
      test_early_exit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
